// File: rtl/mdio_phy_slave.sv
// mdio_phy_slave: PHY-side MDIO management slave serving a small local register file.
// Define MDIO_PREAMBLE_CHECK_EN to require 32 idle ones before a start is accepted.
//
// state | meaning
// IDLE  | line idle, waiting for the first start bit (0)
// START | waiting for the second start bit (1)
// OP    | two opcode bits: 10 read, 01 write
// PHYAD | PHY address, LSB first
// REGAD | register address, LSB first
// TA    | turnaround: read drives 0 on second bit, write expects 1 then 0
// DATA  | 16 data bits, MSB first
// SKIP  | frame not for us or bad turnaround; count out the remaining bits
module mdio_phy_slave #(
  parameter logic [4:0] PHY_ADDR = 5'd1,
  parameter int         NUM_REGS = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  inout  wire         mdio_inout,
  input  logic [15:0] i_status_data,
  output logic        o_reg_wr_strobe,
  output logic [4:0]  o_reg_wr_addr,
  output logic [15:0] o_reg_wr_data,
  output logic        o_frame_error
);

  typedef enum logic [2:0] {IDLE, START, OP, PHYAD, REGAD, TA, DATA, SKIP} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic        is_rd, is_rd_nxt;
  logic        op_first, op_first_nxt;
  logic        ta_first, ta_first_nxt;
  logic [4:0]  phyad, phyad_nxt;
  logic [4:0]  regad, regad_nxt;
  logic [15:0] sr, sr_nxt;
  logic        oe, oe_nxt;
  logic        mdo, mdo_nxt;
  logic        wr_en;
  logic        err_nxt;
  logic        mdi;
  logic        pre_ok;
  logic [4:0]  regad_full;
  logic [15:0] wr_data_full;
  logic [15:0] rd_val;
  logic [15:0] regs [NUM_REGS];

  assign mdi          = mdio_inout;
  assign mdio_inout   = oe ? mdo : 1'bz;
  assign regad_full   = {mdi, regad[4:1]};
  assign wr_data_full = {sr[14:0], mdi};

`ifdef MDIO_PREAMBLE_CHECK_EN
  // Down-counter of consecutive idle ones; reloads on any 0 and outside IDLE.
  logic [5:0] pre_cnt, pre_cnt_nxt;

  assign pre_ok = (pre_cnt == 6'd0);

  always_comb begin
    pre_cnt_nxt = 6'd32;
    if (state == IDLE && mdi) pre_cnt_nxt = pre_ok ? pre_cnt : pre_cnt - 6'd1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) pre_cnt <= 6'd32;
    else         pre_cnt <= pre_cnt_nxt;
  end
`else
  assign pre_ok = 1'b1;
`endif

  always_comb begin
    rd_val = 16'h0000;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (regad_full == 5'(i)) rd_val = regs[i];
    end
    if (regad_full == 5'd1) rd_val = i_status_data;
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    is_rd_nxt    = is_rd;
    op_first_nxt = op_first;
    ta_first_nxt = ta_first;
    phyad_nxt    = phyad;
    regad_nxt    = regad;
    sr_nxt       = sr;
    oe_nxt       = oe;
    mdo_nxt      = mdo;
    wr_en        = 1'b0;
    err_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (!mdi && pre_ok) state_nxt = START;
      end
      START: begin
        if (mdi) begin
          state_nxt = OP;
          cnt_nxt   = 5'd1;
        end
      end
      OP: begin
        op_first_nxt = mdi;
        cnt_nxt      = cnt - 5'd1;
        if (cnt == 5'd0) begin
          if (op_first != mdi) begin
            is_rd_nxt = op_first;
            state_nxt = PHYAD;
            cnt_nxt   = 5'd4;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      PHYAD: begin
        phyad_nxt = {mdi, phyad[4:1]};
        cnt_nxt   = cnt - 5'd1;
        if (cnt == 5'd0) begin
          state_nxt = REGAD;
          cnt_nxt   = 5'd4;
        end
      end
      REGAD: begin
        regad_nxt = regad_full;
        cnt_nxt   = cnt - 5'd1;
        if (cnt == 5'd0) begin
          if (phyad != PHY_ADDR) begin
            state_nxt = SKIP;
            cnt_nxt   = 5'd17;
          end else begin
            state_nxt = TA;
            cnt_nxt   = 5'd1;
            if (is_rd) sr_nxt = rd_val;
          end
        end
      end
      TA: begin
        ta_first_nxt = mdi;
        cnt_nxt      = cnt - 5'd1;
        if (is_rd) begin
          oe_nxt = 1'b1;
          if (cnt != 5'd0) begin
            mdo_nxt = 1'b0;
          end else begin
            mdo_nxt   = sr[15];
            sr_nxt    = {sr[14:0], 1'b0};
            state_nxt = DATA;
            cnt_nxt   = 5'd15;
          end
        end else if (cnt == 5'd0) begin
          cnt_nxt = 5'd15;
          if (ta_first && !mdi) begin
            state_nxt = DATA;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = SKIP;
          end
        end
      end
      DATA: begin
        cnt_nxt = cnt - 5'd1;
        if (is_rd) begin
          mdo_nxt = sr[15];
          sr_nxt  = {sr[14:0], 1'b0};
          if (cnt == 5'd0) begin
            oe_nxt    = 1'b0;
            mdo_nxt   = 1'b0;
            state_nxt = IDLE;
          end
        end else begin
          sr_nxt = wr_data_full;
          if (cnt == 5'd0) begin
            wr_en     = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      SKIP: begin
        cnt_nxt = cnt - 5'd1;
        if (cnt == 5'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state           <= IDLE;
      cnt             <= 5'd0;
      is_rd           <= 1'b0;
      op_first        <= 1'b0;
      ta_first        <= 1'b0;
      phyad           <= 5'd0;
      regad           <= 5'd0;
      sr              <= 16'h0000;
      oe              <= 1'b0;
      mdo             <= 1'b0;
      o_reg_wr_strobe <= 1'b0;
      o_reg_wr_addr   <= 5'd0;
      o_reg_wr_data   <= 16'h0000;
      o_frame_error   <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      is_rd           <= is_rd_nxt;
      op_first        <= op_first_nxt;
      ta_first        <= ta_first_nxt;
      phyad           <= phyad_nxt;
      regad           <= regad_nxt;
      sr              <= sr_nxt;
      oe              <= oe_nxt;
      mdo             <= mdo_nxt;
      o_reg_wr_strobe <= wr_en;
      o_frame_error   <= err_nxt;
      if (wr_en) begin
        o_reg_wr_addr <= regad;
        o_reg_wr_data <= wr_data_full;
      end
    end
  end

  // Register 1 is the live status input, so its storage slot is never written.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 16'h0000;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && regad == 5'(i) && i != 1) regs[i] <= wr_data_full;
      end
    end
  end

endmodule
